// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encodings and NZCV flag bit positions.
// Imported by the condition-check and conditional-execution blocks, and by any
// later pipelined variant that reuses them.
package cpu_pkg;

    // Instruction condition field encodings (instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions within the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator.
// Ports:
//   cond    in  [3:0]  instruction condition field
//   flags   in  [3:0]  architectural {N,Z,C,V}
//   cond_ex out        1 when the condition passes on flags
// The reserved encoding (COND_NV) never passes.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;   // COND_NV: reserved, never executes
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage behind the instruction decoder.
// Holds the NZCV flags, evaluates the condition field against them, gates the
// decoder write strobes, commits ALU flags and counts executed/skipped
// instructions with saturating counters.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   instr_valid                 real instruction this cycle (low = bubble)
//   cond[3:0], alu_flags[3:0]   condition field, ALU {N,Z,C,V}
//   flag_w[1:0]                 [1] N/Z group, [0] C/V group write enables
//   pcs, reg_w, mem_w, no_write decoder requests
//   cond_ex, pc_src, reg_write, mem_write   combinational gated outputs
//   flags[3:0]                  registered {N,Z,C,V}
//   exec_count, skip_count      saturating instruction counters
module cond_logic
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    output logic             cond_ex,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       flags_reg, flags_next;
    logic [CNT_W-1:0] exec_reg, exec_next;
    logic [CNT_W-1:0] skip_reg, skip_next;
    logic             commit;

    // Condition is always evaluated on the registered flags, so an
    // instruction sees the flags of its predecessor, never its own.
    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags_reg),
        .cond_ex (cond_ex)
    );

    assign commit    = instr_valid & cond_ex;
    assign pc_src    = pcs & commit;
    assign reg_write = reg_w & commit & ~no_write;
    assign mem_write = mem_w & commit;

    // Flag group gi covers flags[2*gi+1 : 2*gi]; flag_w[gi] enables it.
    // That maps flag_w[1] -> {N,Z} and flag_w[0] -> {C,V}.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_grp
            assign flags_next[2*gi+1 -: 2] = (commit && flag_w[gi])
                                           ? alu_flags[2*gi+1 -: 2]
                                           : flags_reg[2*gi+1 -: 2];
        end
    endgenerate

    // Exactly one counter moves per valid instruction; both hold at all-ones.
    always_comb begin
        exec_next = exec_reg;
        skip_next = skip_reg;
        if (instr_valid) begin
            if (cond_ex) begin
                if (exec_reg != CNT_MAX) exec_next = exec_reg + 1'b1;
            end else begin
                if (skip_reg != CNT_MAX) skip_next = skip_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg <= 4'b0000;
            exec_reg  <= '0;
            skip_reg  <= '0;
        end else begin
            flags_reg <= flags_next;
            exec_reg  <= exec_next;
            skip_reg  <= skip_next;
        end
    end

    assign flags      = flags_reg;
    assign exec_count = exec_reg;
    assign skip_count = skip_reg;

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
Conditional-execution stage directly downstream of the instruction decoder in the single-cycle CPU. It holds the architectural NZCV flags and evaluates the instruction condition field against them. It gates the decoder's pcs/reg_w/mem_w strobes and commits new ALU flags under the decoder's flag_w enables. It also keeps saturating executed/skipped instruction counters for bring-up visibility.

Parameters:
CNT_W, 16, width of the executed/skipped instruction counters (min 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  current-cycle instruction is real; low = bubble
cond  input  4  instruction condition field, bits [31:28]
alu_flags  input  4  ALU result flags {N,Z,C,V}
flag_w  input  2  decoder flag-write enables: [1] N/Z group, [0] C/V group
pcs  input  1  decoder PC-write request
reg_w  input  1  decoder register-write request
mem_w  input  1  decoder memory-write request
no_write  input  1  decoder: flag-setting compare, suppress register write
cond_ex  output  1  condition passes on current flags (combinational)
pc_src  output  1  gated PC-write strobe
reg_write  output  1  gated register-file write strobe
mem_write  output  1  gated data-memory write strobe
flags  output  4  registered architectural {N,Z,C,V}
exec_count  output  CNT_W  instructions executed (cond passed)
skip_count  output  CNT_W  instructions squashed (cond failed)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: flags=4'b0000, exec_count=0, skip_count=0. Combinational outputs follow their equations.
- Reset wins over any same-cycle flag write or counter increment.
- Reset asserted mid-program takes effect at the next edge. The instruction in that cycle still drives its combinational strobes, but none of its state commits.
- Condition decode uses registered flags only, never alu_flags. Flag update latency is 1 cycle: an instruction sees flags written by the previous instruction, not its own.
- cond decode, with N,Z,C,V taken from flags:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111 reserved: forced 0 (never executes)
- Combinational gating:
  - pc_src = pcs & cond_ex & instr_valid
  - reg_write = reg_w & cond_ex & instr_valid & !no_write
  - mem_write = mem_w & cond_ex & instr_valid
- Flag commit, at the edge, when instr_valid & cond_ex:
  - flag_w[1] loads flags[3:2] from alu_flags[3:2].
  - flag_w[0] loads flags[1:0] from alu_flags[1:0].
  - Groups are independent. Both set loads all four bits; neither set holds.
  - A failed condition never writes flags, whatever flag_w is.
- Counters, when instr_valid: cond_ex=1 increments exec_count; else skip_count increments.
  - Exactly one counter moves per valid cycle; none moves on a bubble.
  - Both counters saturate at all-ones and do not wrap.
- no_write has no effect on flags or counters, only on reg_write.

Decomposition:
- Shared package cpu_pkg:
  - cond-code localparams COND_EQ … COND_AL, COND_NV
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One natural combinational sub-module, cond_check: inputs cond and flags, output cond_ex. It is reusable by a later pipelined design.
- Flag registers, gating and counters stay in cond_logic.

Test Plan:
- Reset then AL add, with reg_w=1, flag_w=2'b11, alu_flags=4'b0100 -> cond_ex=1, reg_write=1; next cycle flags=4'b0100, exec_count=1.
- flags=0100, then EQ str (mem_w=1) -> mem_write=1. Then NE str -> mem_write=0, skip_count increments, flags unchanged.
- CMP: AL, no_write=1, reg_w=1, flag_w=11, alu_flags=1000 -> reg_write=0, flags=1000 next cycle. Following LT branch (pcs=1) -> pc_src=1; GE branch -> pc_src=0.
- flag_w=2'b10 with alu_flags=1111 from flags=0000 -> flags=1100 (C/V held). Then flag_w=2'b01 with alu_flags=0011 -> flags=1111.
- cond=1111 with pcs=reg_w=mem_w=1 -> all strobes 0, skip_count increments. instr_valid=0 with AL -> strobes 0, no counter or flag change.
- CNT_W=2: 5 valid AL instrs -> exec_count saturates at 3. Reset asserted together with an AL flag write -> flags=0 and counters=0 next cycle.
